// File: rtl/rh_dma_seq.sv
`default_nettype none
// ============================================================================
// Module      : rh_dma_seq
// Description : RH11 DMA transfer sequencer. Moves one word per bus cycle
//               between the RH11 data buffer and the KS10 bus until WC wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module rh_dma_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devRESET,
    input  logic        rhCLR,
    input  logic        rhGO,
    input  logic        rhDIR,
    input  logic [15:0] rhWC,
    input  logic        dbufEMPTY,
    input  logic        dbufFULL,
    input  logic        dmaACK,
    output logic        dmaREQ,
    output logic        dmaWR,
    output logic        dbufPOP,
    output logic        dbufPUSH,
    output logic        rhINCWC,
    output logic        rhINCBA,
    output logic        xferBUSY,
    output logic        xferDONE,
    output logic        nxmERR
);

    generate
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("rh_dma_seq: TIMEOUT must be in 1..255");
        end
    endgenerate

    localparam logic [7:0]  c_TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [15:0] c_LAST_WC     = 16'hFFFE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAITBUF = 3'd1,
        ST_REQ     = 3'd2,
        ST_INC     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_tocnt;
    logic       r_dir;
    logic       r_last;
    logic       r_req;
    logic       r_pop;
    logic       r_push;
    logic       r_incwc;
    logic       r_incba;
    logic       r_busy;
    logic       r_done;
    logic       r_nxm;

    logic       w_bufrdy;
    logic [7:0] w_tocnt_nxt;

    // Readiness: a bus write needs data to pop, a bus read needs room to push.
    assign w_bufrdy    = rhDIR ? ~dbufEMPTY : ~dbufFULL;
    assign w_tocnt_nxt = r_tocnt + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_tocnt <= 8'd0;
            r_dir   <= 1'b0;
            r_last  <= 1'b0;
            r_req   <= 1'b0;
            r_pop   <= 1'b0;
            r_push  <= 1'b0;
            r_incwc <= 1'b0;
            r_incba <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nxm   <= 1'b0;
        end else begin
            r_pop   <= 1'b0;
            r_push  <= 1'b0;
            r_incwc <= 1'b0;
            r_incba <= 1'b0;
            r_done  <= 1'b0;
            if (devRESET || rhCLR) begin
                r_state <= ST_IDLE;
                r_req   <= 1'b0;
                r_busy  <= 1'b0;
                r_nxm   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (rhGO) begin
                            r_dir   <= rhDIR;
                            r_nxm   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= ST_WAITBUF;
                        end
                    end
                    ST_WAITBUF: begin
                        if (w_bufrdy) begin
                            r_tocnt <= 8'd0;
                            r_req   <= 1'b1;
                            r_state <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (dmaACK) begin
                            r_last  <= (rhWC == c_LAST_WC);
                            r_req   <= 1'b0;
                            r_incwc <= 1'b1;
                            r_incba <= 1'b1;
                            r_pop   <= r_dir;
                            r_push  <= ~r_dir;
                            r_state <= ST_INC;
                        end else if (w_tocnt_nxt == c_TIMEOUT_CNT) begin
                            // Non-existent memory: abandon the word, no strobes.
                            r_tocnt <= w_tocnt_nxt;
                            r_nxm   <= 1'b1;
                            r_req   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_tocnt <= w_tocnt_nxt;
                        end
                    end
                    ST_INC: begin
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAITBUF;
                        end
                    end
                    ST_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign dmaREQ   = r_req;
    assign dmaWR    = r_dir;
    assign dbufPOP  = r_pop;
    assign dbufPUSH = r_push;
    assign rhINCWC  = r_incwc;
    assign rhINCBA  = r_incba;
    assign xferBUSY = r_busy;
    assign xferDONE = r_done;
    assign nxmERR   = r_nxm;

endmodule
`default_nettype wire

// File: tb/tb_rh_dma_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rh_dma_seq
// Description : Self-checking bench for rh_dma_seq with a transfer-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rh_dma_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        devRESET = 1'b0;
    logic        rhCLR = 1'b0;
    logic        rhGO = 1'b0;
    logic        rhDIR = 1'b0;
    logic [15:0] rhWC = 16'h0;
    logic        dbufEMPTY = 1'b0;
    logic        dbufFULL = 1'b0;
    logic        dmaACK = 1'b0;
    logic        dmaREQ, dmaWR, dbufPOP, dbufPUSH, rhINCWC, rhINCBA;
    logic        xferBUSY, xferDONE, nxmERR;

    int tests = 0;
    int fails = 0;

    rh_dma_seq #(.TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst), .devRESET(devRESET), .rhCLR(rhCLR),
        .rhGO(rhGO), .rhDIR(rhDIR), .rhWC(rhWC),
        .dbufEMPTY(dbufEMPTY), .dbufFULL(dbufFULL), .dmaACK(dmaACK),
        .dmaREQ(dmaREQ), .dmaWR(dmaWR), .dbufPOP(dbufPOP), .dbufPUSH(dbufPUSH),
        .rhINCWC(rhINCWC), .rhINCBA(rhINCBA), .xferBUSY(xferBUSY),
        .xferDONE(xferDONE), .nxmERR(nxmERR)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] all_outs();
        return {dmaREQ, dmaWR, dbufPOP, dbufPUSH, rhINCWC, rhINCBA,
                xferBUSY, xferDONE, nxmERR};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        tests++;
        if (all_outs() !== 9'b0) begin
            fails++;
            $display("FAIL reset_outs: got %b expected %b", all_outs(), 9'b0);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (all_outs() !== 9'b0) begin
            fails++;
            $display("FAIL reset_idle: got %b expected %b", all_outs(), 9'b0);
        end
    endtask

    // Runs one full transfer; expected completion cycle and pulse counts come
    // from word count arithmetic and the bench's own chosen ack delays.
    task automatic run_xfer(input bit dir, input logic [15:0] wc0, input int stall,
                            input int mind, input int maxd, input bit gojunk,
                            input string name);
        int q[$];
        int nwords, predicted, k, cwc, rc, d, budget;
        bit inreq, done_seen, ready;
        logic [15:0] wc;
        nwords = (wc0 == 16'h0) ? 32768 : (65536 - int'(wc0)) / 2;
        predicted = stall;
        for (int i = 0; i < nwords; i++) begin
            d = int'($urandom_range(maxd, mind));
            q.push_back(d);
            predicted += 3 + d;
        end
        budget = predicted + 20;
        wc = wc0;
        cwc = 0; rc = 0; inreq = 1'b0; done_seen = 1'b0;
        rhDIR = dir;
        rhWC = wc;
        dmaACK = 1'b0;
        dbufEMPTY = dir & (stall > 0);
        dbufFULL = ~dir & (stall > 0);
        rhGO = 1'b1;
        tick();
        rhGO = 1'b0;
        k = 0;
        while (!done_seen && k <= budget) begin
            tests++;
            if (xferBUSY !== 1'b1 || dmaWR !== dir || nxmERR !== 1'b0) begin
                fails++;
                $display("FAIL %s_status k=%0d: got busy=%b wr=%b nxm=%b expected 1 %b 0",
                         name, k, xferBUSY, dmaWR, nxmERR, dir);
            end
            tests++;
            if (rhINCWC === 1'b1) begin
                wc = wc + 16'd2;
                cwc++;
                if ({rhINCBA, dbufPOP, dbufPUSH, dmaREQ} !== {1'b1, dir, ~dir, 1'b0}) begin
                    fails++;
                    $display("FAIL %s_strobes k=%0d: got %b expected %b", name, k,
                             {rhINCBA, dbufPOP, dbufPUSH, dmaREQ}, {1'b1, dir, ~dir, 1'b0});
                end
            end else if ({rhINCBA, dbufPOP, dbufPUSH} !== 3'b000) begin
                fails++;
                $display("FAIL %s_stray_strobe k=%0d: got %b expected 000", name, k,
                         {rhINCBA, dbufPOP, dbufPUSH});
            end
            if (k < stall) begin
                tests++;
                if (dmaREQ !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_stall_req k=%0d: got %b expected 0", name, k, dmaREQ);
                end
            end
            if (xferDONE === 1'b1) begin
                done_seen = 1'b1;
                tests++;
                if (k !== predicted || cwc !== nwords) begin
                    fails++;
                    $display("FAIL %s_done: got cycle=%0d words=%0d expected cycle=%0d words=%0d",
                             name, k, cwc, predicted, nwords);
                end
            end
            if (dmaREQ === 1'b1) begin
                if (!inreq) begin
                    inreq = 1'b1;
                    rc = 0;
                    d = (q.size() > 0) ? q.pop_front() : 0;
                end
                rc++;
                dmaACK = (rc > d);
            end else begin
                inreq = 1'b0;
                dmaACK = 1'b0;
            end
            ready = (k >= stall);
            if (dir) begin
                dbufEMPTY = ~ready;
                dbufFULL = 1'($urandom_range(0, 1));
            end else begin
                dbufFULL = ~ready;
                dbufEMPTY = 1'($urandom_range(0, 1));
            end
            rhWC = wc;
            rhGO = gojunk && xferBUSY && !xferDONE && ($urandom_range(0, 3) == 0);
            tick();
            k++;
        end
        rhGO = 1'b0;
        dmaACK = 1'b0;
        if (!done_seen) begin
            tests++;
            fails++;
            $display("FAIL %s_no_done: got no xferDONE in %0d cycles expected one", name, budget);
        end
        tests++;
        if ({xferBUSY, xferDONE, nxmERR} !== 3'b000) begin
            fails++;
            $display("FAIL %s_after: got %b expected 000", name, {xferBUSY, xferDONE, nxmERR});
        end
        dbufEMPTY = 1'b0;
        dbufFULL = 1'b0;
    endtask

    task automatic test_single_word();
        run_xfer(1'b1, 16'hFFFE, 0, 1, 1, 1'b0, "single");
    endtask

    task automatic test_multi_word();
        run_xfer(1'b0, 16'hFFF8, 0, 0, 3, 1'b0, "multi");
    endtask

    task automatic test_buffer_stall();
        run_xfer(1'b0, 16'hFFFC, 20, 0, 1, 1'b0, "stall");
    endtask

    task automatic test_timeout();
        int reqc, cinc, n;
        bit seen;
        rhDIR = 1'b1; dbufEMPTY = 1'b0; dbufFULL = 1'b0; rhWC = 16'hFFF0; dmaACK = 1'b0;
        rhGO = 1'b1;
        tick();
        rhGO = 1'b0;
        reqc = 0; cinc = 0; n = 0; seen = 1'b0;
        while (!seen && n < 60) begin
            if (nxmERR === 1'b1) begin
                seen = 1'b1;
                tests++;
                if (reqc !== 8 || cinc !== 0 || xferDONE !== 1'b1 || dmaREQ !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_nxm: got req_cycles=%0d incs=%0d done=%b req=%b expected 8 0 1 0",
                             reqc, cinc, xferDONE, dmaREQ);
                end
            end else begin
                if (dmaREQ === 1'b1) reqc++;
                if (rhINCWC === 1'b1 || rhINCBA === 1'b1) cinc++;
                tick();
                n++;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL timeout_never: got nxmERR=0 expected 1");
        end
        repeat (4) tick();
        tests++;
        if ({xferBUSY, xferDONE, nxmERR} !== 3'b001) begin
            fails++;
            $display("FAIL timeout_sticky: got %b expected 001", {xferBUSY, xferDONE, nxmERR});
        end
        rhGO = 1'b1;
        tick();
        rhGO = 1'b0;
        tests++;
        if ({xferBUSY, nxmERR} !== 2'b10) begin
            fails++;
            $display("FAIL timeout_go_clears: got %b expected 10", {xferBUSY, nxmERR});
        end
        rhCLR = 1'b1;
        tick();
        rhCLR = 1'b0;
        tests++;
        if (xferBUSY !== 1'b0) begin
            fails++;
            $display("FAIL timeout_cleanup: got busy=%b expected 0", xferBUSY);
        end
    endtask

    task automatic test_abort(input bit use_dev);
        int n;
        rhDIR = 1'($urandom_range(0, 1)); dbufEMPTY = 1'b0; dbufFULL = 1'b0;
        rhWC = 16'hFFE0; dmaACK = 1'b0;
        rhGO = 1'b1;
        tick();
        rhGO = 1'b0;
        n = 0;
        while (dmaREQ !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (dmaREQ !== 1'b1) begin
            fails++;
            $display("FAIL abort_noreq: got dmaREQ=%b expected 1", dmaREQ);
        end
        if (use_dev) devRESET = 1'b1; else rhCLR = 1'b1;
        tick();
        devRESET = 1'b0; rhCLR = 1'b0;
        tests++;
        if ({dmaREQ, dbufPOP, dbufPUSH, rhINCWC, rhINCBA, xferBUSY, xferDONE, nxmERR} !== 8'b0) begin
            fails++;
            $display("FAIL abort_clear dev=%b: got %b expected 0", use_dev, all_outs());
        end
        dmaACK = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({dmaREQ, dbufPOP, dbufPUSH, rhINCWC, rhINCBA, xferBUSY, xferDONE} !== 7'b0) begin
                fails++;
                $display("FAIL abort_late_ack dev=%b: got %b expected 0", use_dev, all_outs());
            end
        end
        dmaACK = 1'b0;
        rhGO = 1'b1;
        if (use_dev) devRESET = 1'b1; else rhCLR = 1'b1;
        tick();
        rhGO = 1'b0; devRESET = 1'b0; rhCLR = 1'b0;
        tests++;
        if (xferBUSY !== 1'b0) begin
            fails++;
            $display("FAIL abort_priority dev=%b: got busy=%b expected 0", use_dev, xferBUSY);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int n;
        rhDIR = 1'b1; dbufEMPTY = 1'b0; dbufFULL = 1'b0; rhWC = 16'hFFF0; dmaACK = 1'b0;
        rhGO = 1'b1;
        tick();
        rhGO = 1'b0;
        n = 0;
        while (rhINCWC !== 1'b1 && n < 30) begin
            dmaACK = dmaREQ;
            tick();
            n++;
        end
        dmaACK = 1'b0;
        tests++;
        if (rhINCWC !== 1'b1) begin
            fails++;
            $display("FAIL async_noinc: got rhINCWC=%b expected 1", rhINCWC);
        end
        #3;
        rst = 1'b0;
        #1;
        tests++;
        if (all_outs() !== 9'b0) begin
            fails++;
            $display("FAIL async_reset: got %b expected %b", all_outs(), 9'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        tests++;
        if (all_outs() !== 9'b0) begin
            fails++;
            $display("FAIL async_release: got %b expected %b", all_outs(), 9'b0);
        end
        run_xfer(1'b1, 16'hFFFA, 0, 0, 2, 1'b0, "restart");
    endtask

    task automatic test_random();
        int n;
        logic [15:0] wc0;
        for (int t = 0; t < 8; t++) begin
            n = int'($urandom_range(1, 6));
            wc0 = 16'(65536 - 2 * n);
            run_xfer(1'($urandom_range(0, 1)), wc0, int'($urandom_range(0, 3)),
                     0, 3, 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word();
        test_buffer_stall();
        test_timeout();
        test_abort(1'b0);
        test_abort(1'b1);
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 expected earlier");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
